// File: rtl/button_input_if.sv
// Event bundle from button conditioning to the game logic.
// The master side (button_input) drives it; the slave side (game) consumes it.
interface button_input_if;
    logic       press_valid;
    logic [1:0] press_color;
    logic       release_pulse;
    logic       start_pulse;
    logic [2:0] note;
    logic       multi_err;

    modport master (
        output press_valid, press_color, release_pulse,
        output start_pulse, note, multi_err
    );

    modport slave (
        input press_valid, press_color, release_pulse,
        input start_pulse, note, multi_err
    );
endinterface

// File: rtl/button_input.sv
// Push-button conditioning: synchronize, debounce, edge-detect and arbitrate
// the four color buttons into single press/release events plus a start pulse.
module button_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic             BTNU,
    input  logic             BTNR,
    input  logic             BTND,
    input  logic             BTNL,
    input  logic             BTNC,
    button_input_if.master   evt
);

    localparam int unsigned NB = 5;
    localparam int unsigned NC = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Bit order: U, R, D, L (color codes 0..3), then C at index 4.
    logic [NB-1:0]    raw_w;
    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync2_q;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    stable_d_q;
    logic [CNT_W-1:0] cnt_q [NB];

    logic [NB-1:0]    rise_w;
    logic [NC-1:0]    color_stable_w;
    logic [NC-1:0]    color_rise_w;
    logic [NC-1:0]    held_mask_w;
    logic [NC-1:0]    other_w;
    logic             multi_w;
    logic             single_press_w;

    state_t           state_q;
    logic             press_valid_q;
    logic [1:0]       press_color_q;
    logic             release_pulse_q;
    logic             start_pulse_q;
    logic [2:0]       note_q;
    logic             multi_err_q;

    function automatic logic [1:0] enc_color(input logic [NC-1:0] oh);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < int'(NC); i++) begin
            if (oh[i]) c = 2'(i);
        end
        return c;
    endfunction

    assign raw_w = {BTNC, BTNL, BTND, BTNR, BTNU};

    // Synchronizer and per-button debounce; counter clears at threshold so it never wraps.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            stable_d_q <= '0;
            for (int i = 0; i < int'(NB); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw_w;
            sync2_q    <= sync1_q;
            stable_d_q <= stable_q;
            for (int i = 0; i < int'(NB); i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise_w         = stable_q & ~stable_d_q;
    assign color_stable_w = stable_q[NC-1:0];
    assign color_rise_w   = rise_w[NC-1:0];
    assign held_mask_w    = NC'(4'b0001 << press_color_q);
    assign other_w        = color_stable_w & ~held_mask_w;
    assign multi_w        = (color_stable_w & (color_stable_w - NC'(1))) != '0;
    assign single_press_w = (color_rise_w != '0) && (color_rise_w == color_stable_w);

    // Color arbitration FSM with registered pulses and note.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q         <= ST_IDLE;
            press_valid_q   <= 1'b0;
            press_color_q   <= 2'd0;
            release_pulse_q <= 1'b0;
            start_pulse_q   <= 1'b0;
            note_q          <= 3'd0;
            multi_err_q     <= 1'b0;
        end else begin
            press_valid_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            multi_err_q     <= 1'b0;
            start_pulse_q   <= rise_w[NB-1];
            case (state_q)
                ST_IDLE: begin
                    if (multi_w) begin
                        state_q     <= ST_LOCKOUT;
                        multi_err_q <= 1'b1;
                    end else if (single_press_w) begin
                        state_q       <= ST_HELD;
                        press_valid_q <= 1'b1;
                        press_color_q <= enc_color(color_rise_w);
                        note_q        <= 3'(enc_color(color_rise_w)) + 3'd1;
                    end
                end
                ST_HELD: begin
                    // A second color wins over a simultaneous release of the held one.
                    if (other_w != '0) begin
                        state_q     <= ST_LOCKOUT;
                        multi_err_q <= 1'b1;
                        note_q      <= 3'd0;
                    end else if (!color_stable_w[press_color_q]) begin
                        state_q         <= ST_IDLE;
                        release_pulse_q <= 1'b1;
                        note_q          <= 3'd0;
                    end
                end
                ST_LOCKOUT: begin
                    if (color_stable_w == '0) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    note_q  <= 3'd0;
                end
            endcase
        end
    end

    assign evt.press_valid   = press_valid_q;
    assign evt.press_color   = press_color_q;
    assign evt.release_pulse = release_pulse_q;
    assign evt.start_pulse   = start_pulse_q;
    assign evt.note          = note_q;
    assign evt.multi_err     = multi_err_q;

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with a short debounce window.
`timescale 1ns/1ps
module tb_button_input;

    localparam int unsigned D = 4;

    logic CLK = 1'b0;
    logic CPU_RESETN = 1'b0;
    logic BTNU = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNC = 1'b0;

    button_input_if bus();

    button_input #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .CLK        (CLK),
        .CPU_RESETN (CPU_RESETN),
        .BTNU       (BTNU),
        .BTNR       (BTNR),
        .BTND       (BTND),
        .BTNL       (BTNL),
        .BTNC       (BTNC),
        .evt        (bus.master)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Event counters sampled on the falling edge.
    int n_press = 0, n_rel = 0, n_start = 0, n_multi = 0, n_dbl = 0;
    int last_press_cyc = 0;
    logic prev_pv = 1'b0, prev_rp = 1'b0, prev_sp = 1'b0, prev_me = 1'b0;
    always @(negedge CLK) begin
        if (bus.press_valid) begin
            n_press++;
            last_press_cyc = cyc;
        end
        if (bus.release_pulse) n_rel++;
        if (bus.start_pulse)   n_start++;
        if (bus.multi_err)     n_multi++;
        if ((bus.press_valid && prev_pv) || (bus.release_pulse && prev_rp) ||
            (bus.start_pulse && prev_sp) || (bus.multi_err && prev_me)) n_dbl++;
        prev_pv = bus.press_valid;
        prev_rp = bus.release_pulse;
        prev_sp = bus.start_pulse;
        prev_me = bus.multi_err;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int b_press, b_rel, b_start, b_multi, t0, lat;

    task automatic snap();
        b_press = n_press;
        b_rel   = n_rel;
        b_start = n_start;
        b_multi = n_multi;
    endtask

    initial begin
        // Reset held with BTNU already pressed.
        BTNU = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("rst_outs", int'({bus.press_valid, bus.release_pulse, bus.start_pulse,
                                  bus.multi_err, bus.press_color, bus.note}), 0);
        end
        step(1);
        snap();
        t0 = cyc;
        CPU_RESETN = 1'b1;
        step(15);
        chk("rst_press_cnt", n_press - b_press, 1);
        chk("rst_color", int'(bus.press_color), 0);
        chk("rst_note", int'(bus.note), 1);
        lat = last_press_cyc - t0;
        chk("rst_latency_ok", int'(lat >= int'(D) + 3 && lat <= int'(D) + 4), 1);
        BTNU = 1'b0;
        step(15);
        chk("rst_rel_cnt", n_rel - b_rel, 1);
        chk("rst_rel_note", int'(bus.note), 0);

        // Clean press/release of BTNR.
        snap();
        BTNR = 1'b1;
        step(2);
        chk("clean_note_before", int'(bus.note), 0);
        step(18);
        chk("clean_press_cnt", n_press - b_press, 1);
        chk("clean_color", int'(bus.press_color), 1);
        chk("clean_note_held", int'(bus.note), 2);
        BTNR = 1'b0;
        step(15);
        chk("clean_rel_cnt", n_rel - b_rel, 1);
        chk("clean_note_after", int'(bus.note), 0);
        chk("clean_no_repress", n_press - b_press, 1);

        // Bounce on BTND: toggle every 2 cycles, end low, then settle high.
        snap();
        for (int i = 0; i < 16; i++) begin
            BTND = ~BTND;
            step(2);
        end
        chk("bounce_quiet", (n_press - b_press) + (n_rel - b_rel) + (n_multi - b_multi), 0);
        t0 = cyc;
        BTND = 1'b1;
        step(15);
        chk("bounce_press_cnt", n_press - b_press, 1);
        chk("bounce_color", int'(bus.press_color), 2);
        lat = last_press_cyc - t0;
        chk("bounce_latency_ok", int'(lat >= int'(D) + 3 && lat <= int'(D) + 4), 1);
        BTND = 1'b0;
        step(15);
        chk("bounce_rel_cnt", n_rel - b_rel, 1);

        // Simultaneous U+L press.
        snap();
        BTNU = 1'b1;
        BTNL = 1'b1;
        step(15);
        chk("simul_multi", n_multi - b_multi, 1);
        chk("simul_no_press", n_press - b_press, 0);
        chk("simul_note", int'(bus.note), 0);
        BTNU = 1'b0;
        BTNL = 1'b0;
        step(15);
        chk("simul_no_rel", n_rel - b_rel, 0);
        BTNL = 1'b1;
        step(15);
        chk("simul_l_press", n_press - b_press, 1);
        chk("simul_l_color", int'(bus.press_color), 3);
        chk("simul_l_note", int'(bus.note), 4);

        // Start while BTNL is held.
        snap();
        BTNC = 1'b1;
        step(15);
        chk("start_cnt", n_start - b_start, 1);
        chk("start_note", int'(bus.note), 4);
        chk("start_no_color_evt", (n_press - b_press) + (n_rel - b_rel) + (n_multi - b_multi), 0);
        BTNC = 1'b0;
        step(15);
        chk("start_once", n_start - b_start, 1);
        BTNL = 1'b0;
        step(15);
        chk("start_l_rel", n_rel - b_rel, 1);

        // Second button while held, then lockout behaviour.
        snap();
        BTNU = 1'b1;
        step(15);
        chk("second_u_press", n_press - b_press, 1);
        BTNR = 1'b1;
        step(15);
        chk("second_multi", n_multi - b_multi, 1);
        chk("second_note", int'(bus.note), 0);
        chk("second_no_rel", n_rel - b_rel, 0);
        BTNU = 1'b0;
        step(15);
        BTNU = 1'b1;
        step(15);
        chk("lockout_holds", (n_press - b_press) + (n_rel - b_rel), 1);
        chk("lockout_note", int'(bus.note), 0);
        BTNU = 1'b0;
        BTNR = 1'b0;
        step(15);
        BTNR = 1'b1;
        step(15);
        chk("lockout_exit_press", n_press - b_press, 2);
        chk("lockout_exit_color", int'(bus.press_color), 1);
        BTNR = 1'b0;
        step(15);

        chk("pulse_width", n_dbl, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
